// File: rtl/pid_sched_pkg.sv
// pid_sched_pkg: shared types and helpers for the PID channel scheduler.
//   state_t  - scheduler FSM states (encoding is visible in STATUS[4:2])
//   ADDR_*   - CPU bus word addresses
//   sat32    - saturating 32-bit signed subtraction
package pid_sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_T = 3'd1,
        SCAN   = 3'd2,
        ISSUE  = 3'd3,
        WAIT_D = 3'd4,
        STORE  = 3'd5
    } state_t;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_PERIOD = 4'd1;
    localparam logic [3:0] ADDR_STATUS = 4'd2;
    localparam logic [3:0] ADDR_SP     = 4'd3;
    localparam logic [3:0] ADDR_RES    = 4'd8;

    // a - b with clamping to the signed 32-bit range
    function automatic logic [31:0] sat32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] d;
        d = {a[31], a} - {b[31], b};
        if (d[32] != d[31])
            return d[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return d[31:0];
    endfunction

endpackage

// File: rtl/pid_channel_scheduler_if.sv
// pid_channel_scheduler_if: CPU bus, PID core handshake and result link signals.
//   slave  - scheduler side (drives readData, pid_*, out_*)
//   master - environment side (drives bus strobes, pid_done, pid_result)
interface pid_channel_scheduler_if;
    logic        chipSelect;
    logic        write;
    logic        read;
    logic [3:0]  address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        pid_start;
    logic [2:0]  pid_chan;
    logic [31:0] pid_err;
    logic        pid_done;
    logic [31:0] pid_result;
    logic        out_valid;
    logic [2:0]  out_chan;
    logic [31:0] out_data;

    modport slave (
        input  chipSelect, write, read, address, writeData, pid_done, pid_result,
        output readData, pid_start, pid_chan, pid_err, out_valid, out_chan, out_data
    );

    modport master (
        output chipSelect, write, read, address, writeData, pid_done, pid_result,
        input  readData, pid_start, pid_chan, pid_err, out_valid, out_chan, out_data
    );
endinterface

// File: rtl/pid_tick_gen.sv
// pid_tick_gen: sample-period down-counter.
//   clk, rst (async active-low), run (count enable), period (requested period),
//   tick (one-cycle pulse when the counter reaches 0).
// Reload value is max(period,2)-1; while run=0 the counter is held at the
// reload value, so the first tick comes a full period after run is set.
module pid_tick_gen #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reload;

    assign reload = (period < CNT_W'(2)) ? CNT_W'(1) : period - CNT_W'(1);
    assign tick   = run && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (!run || cnt == '0)
            cnt <= reload;
        else
            cnt <= cnt - CNT_W'(1);
    end
endmodule

// File: rtl/pid_channel_scheduler.sv
// pid_channel_scheduler: time-multiplexes one PID core across NCH channels.
//   clk      system clock
//   rst      asynchronous active-low reset
//   sif      bus / PID handshake / result link (pid_channel_scheduler_if.slave)
//   meas_in  signed measurements, ch0 in [31:0]
// Optional feature: define PID_WDOG_EN to enable the WAIT_D watchdog
// (abort after 65535 cycles without pid_done, result 0, STATUS[1] set).
module pid_channel_scheduler
    import pid_sched_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    pid_channel_scheduler_if.slave sif,
    input  logic [32*NCH-1:0]     meas_in
);
    state_t           state, state_n;
    logic             run;
    logic [NCH-1:0]   mask;
    logic [CNT_W-1:0] period;
    logic [31:0]      sp  [NCH];
    logic [31:0]      res [NCH];
    logic [31:0]      meas[NCH];
    logic             ovr_flag, wdog_flag;
    logic             tick;

    logic [3:0]       next_idx;
    logic [2:0]       cur_ch;
    logic             found;
    logic [2:0]       found_ch;
    logic [31:0]      found_err;
    logic             wd_timeout;
    logic             store_en;
    logic [31:0]      cap;

    logic [31:0]      pid_err_q, out_data_q, rd_data_q, rd_mux;
    logic [2:0]       pid_chan_q, out_chan_q;
    logic             wr_en, rd_en, wr_status;

    assign wr_en     = sif.chipSelect && sif.write;
    assign rd_en     = sif.chipSelect && sif.read && !sif.write;
    assign wr_status = wr_en && (sif.address == ADDR_STATUS);

    pid_tick_gen #(.CNT_W(CNT_W)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++)
            meas[i] = meas_in[32*i +: 32];
    end

    // Lowest enabled channel at or above next_idx; mask is sampled here.
    always_comb begin
        found     = 1'b0;
        found_ch  = '0;
        found_err = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && mask[i] && (i >= 32'(next_idx))) begin
                found     = 1'b1;
                found_ch  = 3'(i);
                found_err = sat32(sp[i], meas[i]);
            end
        end
    end

`ifdef PID_WDOG_EN
    logic [15:0] wd_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wd_cnt <= '0;
        else if (state == WAIT_D && !sif.pid_done)
            wd_cnt <= wd_cnt + 16'd1;
        else
            wd_cnt <= '0;
    end
    // wd_cnt == FFFE marks the 65535th WAIT_D cycle without pid_done
    assign wd_timeout = (state == WAIT_D) && !sif.pid_done && (wd_cnt == 16'hFFFE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wdog_flag <= 1'b0;
        else
            wdog_flag <= (wdog_flag && !(wr_status && sif.writeData[1])) || wd_timeout;
    end
`else
    assign wd_timeout = 1'b0;
    assign wdog_flag  = 1'b0;
`endif

    assign store_en = (state == WAIT_D) && (sif.pid_done || wd_timeout);
    assign cap      = sif.pid_done ? sif.pid_result : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (run) state_n = WAIT_T;
            WAIT_T:  if (!run) state_n = IDLE;
                     else if (tick) state_n = SCAN;
            SCAN:    state_n = found ? ISSUE : WAIT_T;
            ISSUE:   state_n = WAIT_D;
            WAIT_D:  if (store_en) state_n = STORE;
            STORE:   state_n = run ? SCAN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Channel bookkeeping and result capture. The result is registered on the
    // pid_done edge so it is already on out_data/RESULT while STORE pulses out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_idx   <= '0;
            cur_ch     <= '0;
            pid_chan_q <= '0;
            pid_err_q  <= '0;
            out_data_q <= '0;
            out_chan_q <= '0;
            for (int unsigned i = 0; i < NCH; i++)
                res[i] <= '0;
        end else begin
            if (state == WAIT_T && tick)
                next_idx <= '0;
            if (state == SCAN && found) begin
                cur_ch     <= found_ch;
                next_idx   <= 4'(found_ch) + 4'd1;
                pid_chan_q <= found_ch;
                pid_err_q  <= found_err;
            end
            if (store_en) begin
                out_data_q <= cap;
                out_chan_q <= cur_ch;
                for (int unsigned i = 0; i < NCH; i++)
                    if (3'(i) == cur_ch)
                        res[i] <= cap;
            end
        end
    end

    // Register file; overrun set wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            mask     <= '0;
            period   <= '0;
            ovr_flag <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++)
                sp[i] <= '0;
        end else begin
            ovr_flag <= (ovr_flag && !(wr_status && sif.writeData[0])) ||
                        (tick && state != WAIT_T);
            if (wr_en) begin
                case (sif.address)
                    ADDR_CTRL: begin
                        run  <= sif.writeData[0];
                        mask <= sif.writeData[NCH:1];
                    end
                    ADDR_PERIOD: period <= sif.writeData[CNT_W-1:0];
                    default: begin
                        for (int unsigned i = 0; i < NCH; i++)
                            if (sif.address == ADDR_SP + 4'(i))
                                sp[i] <= sif.writeData;
                    end
                endcase
            end
        end
    end

    // Read mux; setpoints take priority where the windows overlap (NCH > 5)
    always_comb begin
        rd_mux = '0;
        case (sif.address)
            ADDR_CTRL:   rd_mux = 32'({mask, run});
            ADDR_PERIOD: rd_mux = 32'(period);
            ADDR_STATUS: rd_mux = {27'd0, state, wdog_flag, ovr_flag};
            default: begin
                for (int unsigned i = 0; i < NCH; i++)
                    if (sif.address == ADDR_RES + 4'(i))
                        rd_mux = res[i];
                for (int unsigned i = 0; i < NCH; i++)
                    if (sif.address == ADDR_SP + 4'(i))
                        rd_mux = sp[i];
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rd_data_q <= '0;
        else if (rd_en)
            rd_data_q <= rd_mux;
    end

    assign sif.readData  = rd_data_q;
    assign sif.pid_start = (state == ISSUE);
    assign sif.pid_chan  = pid_chan_q;
    assign sif.pid_err   = pid_err_q;
    assign sif.out_valid = (state == STORE);
    assign sif.out_chan  = out_chan_q;
    assign sif.out_data  = out_data_q;

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Bench for pid_channel_scheduler: register table vectors plus directed
// sweep, saturation, overrun, run-clear, short-period, stray-done and reset sequences.
module tb_pid_channel_scheduler;
    import pid_sched_pkg::*;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pid_channel_scheduler_if sif();
    logic [32*NCH-1:0] meas_in;

    pid_channel_scheduler #(.NCH(NCH), .CNT_W(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .sif     (sif),
        .meas_in (meas_in)
    );

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] d;
    } res_t;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int done_cyc = 0;
    int n_ov = 0;
    int n_start[8];
    int core_lat = 3;
    int stray_req = 0;
    logic [31:0] exp_err[8];
    res_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sif.chipSelect = 1'b1; sif.write = 1'b1; sif.address = a; sif.writeData = d;
        @(negedge clk);
        sif.chipSelect = 1'b0; sif.write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        sif.chipSelect = 1'b1; sif.read = 1'b1; sif.address = a;
        @(negedge clk);
        d = sif.readData;
        sif.chipSelect = 1'b0; sif.read = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (sif.pid_start === 1'b1) ok = 1'b1;
        end
    endtask

    // PID core model: done core_lat cycles after start, result = err + 1000
    initial begin : core_model
        int stray_seen;
        logic [2:0]  ch;
        logic [31:0] e, r;
        stray_seen = 0;
        sif.pid_done = 1'b0;
        sif.pid_result = '0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_seen) begin
                stray_seen++;
                sif.pid_done = 1'b1; sif.pid_result = 32'hDEAD_0000;
                @(negedge clk);
                sif.pid_done = 1'b0; sif.pid_result = '0;
            end else if (sif.pid_start === 1'b1) begin
                ch = sif.pid_chan;
                e  = sif.pid_err;
                n_start[ch]++;
                check($sformatf("pid_err_ch%0d", ch), e, exp_err[ch]);
                repeat (core_lat) @(negedge clk);
                r = e + 32'd1000;
                sif.pid_done = 1'b1; sif.pid_result = r;
                done_cyc = cyc;
                exp_q.push_back('{ch: ch, d: r});
                @(negedge clk);
                sif.pid_done = 1'b0; sif.pid_result = '0;
            end
        end
    end

    initial begin : out_monitor
        res_t x;
        forever begin
            @(negedge clk);
            if (sif.out_valid === 1'b1) begin
                n_ov++;
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    check("out_data", sif.out_data, x.d);
                    check("out_chan", 32'(sif.out_chan), 32'(x.ch));
                    check("out_latency", cyc - done_cyc, 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        vec_t vt[16];
        int s[8];
        int ov0, tot0;
        bit ok;
        int scan_n;
        bit alt;
        logic [2:0] st, prev;

        vt[0]  = '{0, 4'd0,  32'h0,         32'h0};
        vt[1]  = '{0, 4'd1,  32'h0,         32'h0};
        vt[2]  = '{0, 4'd2,  32'h0,         32'h0};
        vt[3]  = '{0, 4'd3,  32'h0,         32'h0};
        vt[4]  = '{0, 4'd8,  32'h0,         32'h0};
        vt[5]  = '{1, 4'd4,  32'h1234_5678, 32'h0};
        vt[6]  = '{0, 4'd4,  32'h0,         32'h1234_5678};
        vt[7]  = '{1, 4'd1,  32'hFFAB_CDEF, 32'h0};
        vt[8]  = '{0, 4'd1,  32'h0,         32'h00AB_CDEF};
        vt[9]  = '{1, 4'd7,  32'h0000_0005, 32'h0};
        vt[10] = '{0, 4'd7,  32'h0,         32'h0};
        vt[11] = '{1, 4'd8,  32'h0000_0055, 32'h0};
        vt[12] = '{0, 4'd8,  32'h0,         32'h0};
        vt[13] = '{1, 4'd0,  32'hFFFF_FFFE, 32'h0};
        vt[14] = '{0, 4'd0,  32'h0,         32'h0000_001E};
        vt[15] = '{0, 4'd15, 32'h0,         32'h0};

        for (int i = 0; i < 8; i++) begin n_start[i] = 0; exp_err[i] = '0; end
        sif.chipSelect = 1'b0; sif.write = 1'b0; sif.read = 1'b0;
        sif.address = '0; sif.writeData = '0;
        meas_in = '0;

        rst = 1'b1;
        #2 rst = 1'b0;
        wait_cyc(3);
        check("rst_readData",  sif.readData, 32'h0);
        check("rst_pid_start", 32'(sif.pid_start), 32'h0);
        check("rst_out_valid", 32'(sif.out_valid), 32'h0);
        check("rst_pid_err",   sif.pid_err, 32'h0);
        check("rst_out_data",  sif.out_data, 32'h0);
        rst = 1'b1;
        wait_cyc(2);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].wr) bus_write(vt[i].addr, vt[i].data);
            else read_check($sformatf("vec%0d", i), vt[i].addr, vt[i].exp);
        end
        bus_write(ADDR_CTRL, 32'h0);

        // Sweep: mask 0101, two ticks
        bus_write(4'd3, 32'd100);
        bus_write(4'd5, 32'd7);
        meas_in[31:0]  = 32'd30;
        meas_in[95:64] = 32'hFFFF_FFFB;
        exp_err[0] = 32'd70;
        exp_err[2] = 32'd12;
        core_lat = 3;
        bus_write(ADDR_PERIOD, 32'd30);
        for (int i = 0; i < 8; i++) s[i] = n_start[i];
        ov0 = n_ov;
        bus_write(ADDR_CTRL, 32'h0000_000B);
        wait_cyc(80);
        bus_write(ADDR_CTRL, 32'h0);
        wait_cyc(10);
        check("sweep_ch0_starts", n_start[0] - s[0], 32'd2);
        check("sweep_ch1_starts", n_start[1] - s[1], 32'd0);
        check("sweep_ch2_starts", n_start[2] - s[2], 32'd2);
        check("sweep_ch3_starts", n_start[3] - s[3], 32'd0);
        check("sweep_out_valids", n_ov - ov0, 32'd4);
        read_check("sweep_result0", 4'd8,  32'd1070);
        read_check("sweep_result2", 4'd10, 32'd1012);
        read_check("sweep_status",  ADDR_STATUS, 32'h0);

        // Saturation at both ends
        bus_write(4'd3, 32'h7FFF_FFFF);
        bus_write(4'd4, 32'h8000_0000);
        meas_in[31:0]  = 32'hFFFF_FFFF;
        meas_in[63:32] = 32'd1;
        exp_err[0] = 32'h7FFF_FFFF;
        exp_err[1] = 32'h8000_0000;
        for (int i = 0; i < 8; i++) s[i] = n_start[i];
        bus_write(ADDR_CTRL, 32'h0000_0007);
        wait_cyc(50);
        bus_write(ADDR_CTRL, 32'h0);
        wait_cyc(10);
        check("sat_ch0_starts", n_start[0] - s[0], 32'd1);
        check("sat_ch1_starts", n_start[1] - s[1], 32'd1);
        read_check("sat_result0", 4'd8, 32'h8000_03E7);
        read_check("sat_result1", 4'd9, 32'h8000_03E8);

        // Overrun: short period, slow core
        core_lat = 20;
        bus_write(ADDR_PERIOD, 32'd4);
        bus_write(ADDR_CTRL, 32'h0000_0003);
        wait_cyc(30);
        bus_write(ADDR_CTRL, 32'h0);
        wait_cyc(40);
        read_check("ovr_status_set", ADDR_STATUS, 32'h1);
        bus_write(ADDR_STATUS, 32'h1);
        read_check("ovr_status_clr", ADDR_STATUS, 32'h0);

        // Clear run while waiting for pid_done
        core_lat = 10;
        bus_write(ADDR_PERIOD, 32'd30);
        tot0 = n_start[0];
        ov0 = n_ov;
        bus_write(ADDR_CTRL, 32'h0000_0003);
        wait_start(ok);
        check("runclr_start_seen", 32'(ok), 32'd1);
        bus_write(ADDR_CTRL, 32'h0);
        wait_cyc(60);
        check("runclr_starts", n_start[0] - tot0, 32'd1);
        check("runclr_out_valids", n_ov - ov0, 32'd1);
        read_check("runclr_status", ADDR_STATUS, 32'h0);

        // PERIOD 0/1 with empty mask: WAIT_T/SCAN alternate every cycle
        for (int p = 0; p < 2; p++) begin
            bus_write(ADDR_PERIOD, 32'(p));
            tot0 = n_start[0] + n_start[1] + n_start[2] + n_start[3];
            ov0 = n_ov;
            bus_write(ADDR_CTRL, 32'h0000_0001);
            wait_cyc(4);
            @(negedge clk);
            sif.chipSelect = 1'b1; sif.read = 1'b1; sif.address = ADDR_STATUS;
            scan_n = 0;
            alt = 1'b1;
            prev = '0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                st = sif.readData[4:2];
                if (st == SCAN) scan_n++;
                if (st != SCAN && st != WAIT_T) alt = 1'b0;
                if (k > 0 && st == prev) alt = 1'b0;
                prev = st;
            end
            sif.chipSelect = 1'b0; sif.read = 1'b0;
            bus_write(ADDR_CTRL, 32'h0);
            wait_cyc(5);
            check($sformatf("p%0d_scan_count", p), scan_n, 32'd4);
            check($sformatf("p%0d_alternate", p), 32'(alt), 32'd1);
            check($sformatf("p%0d_no_start", p),
                  n_start[0] + n_start[1] + n_start[2] + n_start[3] - tot0, 32'd0);
            check($sformatf("p%0d_no_out", p), n_ov - ov0, 32'd0);
            read_check($sformatf("p%0d_status", p), ADDR_STATUS, 32'h0);
        end

        // pid_done outside WAIT_D
        ov0 = n_ov;
        stray_req++;
        wait_cyc(6);
        check("stray_no_out", n_ov - ov0, 32'd0);
        read_check("stray_result0", 4'd8, 32'h8000_03E7);

        // Async reset during a transaction
        bus_write(ADDR_CTRL, 32'h0000_0003);
        wait_start(ok);
        check("rstmid_start_seen", 32'(ok), 32'd1);
        wait_cyc(2);
        ov0 = n_ov;
        rst = 1'b0;
        wait_cyc(1);
        check("rstmid_pid_start", 32'(sif.pid_start), 32'h0);
        check("rstmid_pid_err",   sif.pid_err, 32'h0);
        check("rstmid_out_data",  sif.out_data, 32'h0);
        wait_cyc(1);
        rst = 1'b1;
        wait_cyc(20);
        check("rstmid_no_out", n_ov - ov0, 32'd0);
        read_check("rstmid_ctrl",   ADDR_CTRL, 32'h0);
        read_check("rstmid_status", ADDR_STATUS, 32'h0);
        read_check("rstmid_result0", 4'd8, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
